// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   mode_t      - instruction mode field instr[7:6]
//   cond_t      - CONDITION test codes instr[2:0]
//   seq_state_t - sequencer FSM states
//   REG_IO      - COPY index selecting the external I/O port
//   REG_RSVD    - COPY index reserved; executing it halts the sequencer
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 6;

    localparam logic [2:0] REG_IO   = 3'd6;
    localparam logic [2:0] REG_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IMMEDIATE = 2'b00,
        CALCULATE = 2'b01,
        COPY      = 2'b10,
        CONDITION = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_EQZ    = 3'b001,
        COND_LTZ    = 3'b010,
        COND_LEZ    = 3'b011,
        COND_ALWAYS = 3'b100,
        COND_NEZ    = 3'b101,
        COND_GEZ    = 3'b110,
        COND_GTZ    = 3'b111
    } cond_t;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        EXEC     = 3'd1,
        WAIT_IN  = 3'd2,
        WAIT_OUT = 3'd3,
        HALT     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/register_file.sv
// register_file: six 8-bit general registers, one write port.
//   clock, reset_n     - rising-edge clock, synchronous active-low clear
//   wr_en/idx/data     - write port; indices >= 6 are ignored
//   src_idx, src_data  - indexed read (returns 0 for indices >= 6)
//   reg0..reg3         - fixed combinational reads used by the sequencer
module register_file
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        src_idx,
    output logic [DATA_W-1:0] src_data,
    output logic [DATA_W-1:0] reg0,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] reg3
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx < 3'(NUM_REGS))) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign src_data = (src_idx < 3'(NUM_REGS)) ? regs[src_idx] : '0;
    assign reg0     = regs[0];
    assign reg1     = regs[1];
    assign reg2     = regs[2];
    assign reg3     = regs[3];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute control for the 8-bit CPU.
//   clock, reset_n            - rising-edge clock, synchronous active-low reset
//   pc, instr_req/data/valid  - program memory fetch interface
//   alu_opcode, alu_a, alu_b  - ALU operands (reg1, reg2) and opcode
//   alu_result                - ALU output, written to reg3 by CALCULATE
//   in_data/valid/ready       - external input port (COPY from index 6)
//   out_data/valid/ready      - external output port (COPY to index 6)
//   halted                    - set when a reserved COPY index is executed
module instruction_sequencer
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    output logic [DATA_W-1:0] pc,
    output logic              instr_req,
    input  logic [DATA_W-1:0] instr_data,
    input  logic              instr_valid,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);

    seq_state_t        state;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] reg0, reg1, reg2, reg3, src_val;
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        src_idx, dst_idx;
    logic              copy_rsvd;
    logic [DATA_W-1:0] pc_inc;
    mode_t             mode;

    function automatic logic cond_true(input cond_t c, input logic signed [DATA_W-1:0] v);
        logic zero, neg;
        zero = (v == '0);
        neg  = (v < 0);
        case (c)
            COND_EQZ:    cond_true = zero;
            COND_LTZ:    cond_true = neg;
            COND_LEZ:    cond_true = neg | zero;
            COND_ALWAYS: cond_true = 1'b1;
            COND_NEZ:    cond_true = ~zero;
            COND_GEZ:    cond_true = ~neg;
            COND_GTZ:    cond_true = ~neg & ~zero;
            default:     cond_true = 1'b0;
        endcase
    endfunction

    assign mode       = mode_t'(instr[7:6]);
    assign src_idx    = instr[5:3];
    assign dst_idx    = instr[2:0];
    assign copy_rsvd  = (src_idx == REG_RSVD) || (dst_idx == REG_RSVD);
    assign pc_inc     = pc + 8'd1;
    assign alu_opcode = instr[2:0];
    assign alu_a      = reg1;
    assign alu_b      = reg2;
    // Input handshake is combinational so a waiting byte is taken in one cycle.
    assign in_ready   = (state == WAIT_IN) && in_valid;

    register_file u_rf (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .src_idx  (src_idx),
        .src_data (src_val),
        .reg0     (reg0),
        .reg1     (reg1),
        .reg2     (reg2),
        .reg3     (reg3)
    );

    // Register write port decode
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = dst_idx;
        wr_data = in_data;
        case (state)
            EXEC: begin
                case (mode)
                    IMMEDIATE: begin
                        wr_en   = 1'b1;
                        wr_idx  = 3'd0;
                        wr_data = {2'b00, instr[5:0]};
                    end
                    CALCULATE: begin
                        wr_en   = 1'b1;
                        wr_idx  = 3'd3;
                        wr_data = alu_result;
                    end
                    COPY: begin
                        wr_en   = !copy_rsvd && (src_idx != REG_IO) && (dst_idx != REG_IO);
                        wr_data = src_val;
                    end
                    default: ;
                endcase
            end
            WAIT_IN: wr_en = in_valid && (dst_idx != REG_IO);
            default: ;
        endcase
    end

    // Sequencer FSM
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= FETCH;
            pc        <= '0;
            instr     <= '0;
            instr_req <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    instr_req <= 1'b1;
                    // Acceptance waits for instr_req so the post-reset cycle never fetches.
                    if (instr_req && instr_valid) begin
                        instr     <= instr_data;
                        instr_req <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    state     <= FETCH;
                    instr_req <= 1'b1;
                    case (mode)
                        COPY: begin
                            if (copy_rsvd) begin
                                state     <= HALT;
                                instr_req <= 1'b0;
                                halted    <= 1'b1;
                            end else if (src_idx == REG_IO) begin
                                state     <= WAIT_IN;
                                instr_req <= 1'b0;
                            end else if (dst_idx == REG_IO) begin
                                out_data  <= src_val;
                                out_valid <= 1'b1;
                                state     <= WAIT_OUT;
                                instr_req <= 1'b0;
                            end else begin
                                pc <= pc_inc;
                            end
                        end
                        CONDITION: pc <= cond_true(cond_t'(instr[2:0]), $signed(reg3)) ? reg0 : pc_inc;
                        default:   pc <= pc_inc;
                    endcase
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        // Input-to-output copy forwards the byte instead of writing a register.
                        if (dst_idx == REG_IO) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= WAIT_OUT;
                        end else begin
                            pc        <= pc_inc;
                            state     <= FETCH;
                            instr_req <= 1'b1;
                        end
                    end
                end
                WAIT_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= FETCH;
                        instr_req <= 1'b1;
                    end
                end
                HALT: begin
                    halted    <= 1'b1;
                    instr_req <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] pc;
    logic       instr_req;
    logic [7:0] instr_data;
    logic       instr_valid;
    logic [2:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    instruction_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc          (pc),
        .instr_req   (instr_req),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .halted      (halted)
    );

    // Reference ALU driving the sequencer's result input.
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_result = alu_a & alu_b;
            3'd1:    alu_result = alu_a | alu_b;
            3'd2:    alu_result = ~(alu_a & alu_b);
            3'd3:    alu_result = ~(alu_a | alu_b);
            3'd4:    alu_result = alu_a + alu_b;
            3'd5:    alu_result = alu_a - alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction; returns with the sequencer in EXEC.
    task automatic fetch(input logic [7:0] b);
        int n;
        n = 0;
        while (!instr_req && n < 20) begin
            step();
            n++;
        end
        chk("fetch_req", {7'd0, instr_req}, 8'd1);
        instr_data  = b;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic run(input logic [7:0] b);
        fetch(b);
        step();
    endtask

    // Copy register idx to the output port and accept it immediately.
    task automatic read_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        fetch({2'b10, idx, 3'd6});
        step();
        chk({tag, "_vld"}, {7'd0, out_valid}, 8'd1);
        chk(tag, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drop"}, {7'd0, out_valid}, 8'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},   pc, 8'h00);
        chk({tag, "_req"},  {7'd0, instr_req}, 8'd0);
        chk({tag, "_rdy"},  {7'd0, in_ready}, 8'd0);
        chk({tag, "_ovld"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_odat"}, out_data, 8'h00);
        chk({tag, "_halt"}, {7'd0, halted}, 8'd0);
        chk({tag, "_a"},    alu_a, 8'h00);
        chk({tag, "_b"},    alu_b, 8'h00);
        chk({tag, "_op"},   {5'd0, alu_opcode}, 8'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_data  = 8'h00;
        instr_valid = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        step();
        step();
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        step();
        chk("req_after_rst", {7'd0, instr_req}, 8'd1);

        // IMMEDIATE 63: two cycles, pc 0 -> 1
        run(8'h3F);
        chk("imm_pc", pc, 8'h01);

        // reg0 -> out with consumer stalling 4 cycles
        fetch(8'h86);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("out_hold_vld", {7'd0, out_valid}, 8'd1);
            chk("out_hold_dat", out_data, 8'h3F);
            chk("out_hold_pc", pc, 8'h01);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_drop", {7'd0, out_valid}, 8'd0);
        chk("out_pc", pc, 8'h02);
        chk("out_fetch", {7'd0, instr_req}, 8'd1);

        // reg1 = 0F, reg2 = 03, SUB
        run(8'h0F);
        run(8'h81);
        chk("reg1_0f", alu_a, 8'h0F);
        run(8'h03);
        run(8'h82);
        chk("reg2_03", alu_b, 8'h03);
        fetch(8'h45);
        chk("sub_op", {5'd0, alu_opcode}, 8'd5);
        step();
        chk("sub_pc", pc, 8'h07);
        read_reg("sub_r3", 3'd3, 8'h0C);

        // reg2 = 10, SUB underflow
        run(8'h10);
        run(8'h82);
        chk("reg2_10", alu_b, 8'h10);
        run(8'h45);
        read_reg("subneg_r3", 3'd3, 8'hFF);
        chk("pc_12", pc, 8'h0C);

        // input -> reg1 with in_valid late
        fetch(8'hB1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("win_rdy_low", {7'd0, in_ready}, 8'd0);
            chk("win_pc", pc, 8'h0C);
            chk("win_req", {7'd0, instr_req}, 8'd0);
            step();
        end
        in_data  = 8'hA5;
        in_valid = 1'b1;
        #1;
        chk("win_rdy_high", {7'd0, in_ready}, 8'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("win_rdy_after", {7'd0, in_ready}, 8'd0);
        chk("in_reg1", alu_a, 8'hA5);
        chk("in_pc", pc, 8'h0D);

        // input 80 -> reg3, with in_valid already high before WAIT_IN
        in_data  = 8'h80;
        in_valid = 1'b1;
        fetch(8'hB3);
        chk("rdy_outside_wait", {7'd0, in_ready}, 8'd0);
        step();
        step();
        in_valid = 1'b0;
        chk("in3_pc", pc, 8'h0E);

        // reg0 = 20; jump on negative taken, on positive not taken
        run(8'h20);
        run(8'hC2);
        chk("jlt_taken", pc, 8'h20);
        run(8'hC7);
        chk("jgt_not", pc, 8'h21);

        // reg0 = FF, jump always, then wrap
        in_data  = 8'hFF;
        in_valid = 1'b1;
        fetch(8'hB0);
        step();
        step();
        in_valid = 1'b0;
        run(8'hC4);
        chk("jmp_ff", pc, 8'hFF);
        run(8'h01);
        chk("pc_wrap", pc, 8'h00);

        // reserved encoding halts
        fetch(8'hBF);
        step();
        chk("halted", {7'd0, halted}, 8'd1);
        chk("halt_req", {7'd0, instr_req}, 8'd0);
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        instr_valid = 1'b0;
        chk("halt_stay", {7'd0, halted}, 8'd1);
        chk("halt_req2", {7'd0, instr_req}, 8'd0);
        chk("halt_pc", pc, 8'h00);

        // reset out of HALT, then reset while in WAIT_OUT
        reset_n = 1'b0;
        step();
        chk("halt_rst", {7'd0, halted}, 8'd0);
        reset_n = 1'b1;
        step();
        run(8'h15);
        fetch(8'h86);
        step();
        chk("wo_vld", {7'd0, out_valid}, 8'd1);
        chk("wo_dat", out_data, 8'h15);
        reset_n = 1'b0;
        step();
        chk_reset_outputs("wo_rst");
        reset_n = 1'b1;
        step();
        read_reg("rst_r0", 3'd0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
